// File: rtl/memory_arbiter_2port.sv
// Round-robin arbiter/sequencer sharing one synchronous single-port memory
// between requesters A and B; one access in flight at a time.
module memory_arbiter_2port #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_a,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] wdata_a,
   output logic                  ack_a,
   output logic [DATA_WIDTH-1:0] rdata_a,
   input  logic                  req_b,
   input  logic                  we_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] wdata_b,
   output logic                  ack_b,
   output logic [DATA_WIDTH-1:0] rdata_b,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_rE,
   output logic                  mem_wE,
   input  logic [DATA_WIDTH-1:0] mem_dataOut,
   output logic                  busy,
   output logic                  grant_b,
   output logic [7:0]            xfer_count
);

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

   state_t                state_q;
   logic                  last_b_q;
   logic                  grant_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  mem_re_q, mem_we_q;
   logic                  ack_a_q, ack_b_q;
   logic [DATA_WIDTH-1:0] rdata_a_q, rdata_b_q;
   logic [7:0]            xfer_q;

   logic                  pick_b_d;
   logic                  we_d;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [DATA_WIDTH-1:0] wdata_d;

   // B wins when it is alone, or when both ask and A was served last.
   always_comb begin
      pick_b_d = req_b & (~req_a | ~last_b_q);
      we_d     = pick_b_d ? we_b    : we_a;
      addr_d   = pick_b_d ? addr_b  : addr_a;
      wdata_d  = pick_b_d ? wdata_b : wdata_a;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         last_b_q  <= 1'b1;
         grant_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         mem_re_q  <= 1'b0;
         mem_we_q  <= 1'b0;
         ack_a_q   <= 1'b0;
         ack_b_q   <= 1'b0;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
         xfer_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_a || req_b) begin
                  grant_q  <= pick_b_d;
                  we_q     <= we_d;
                  addr_q   <= addr_d;
                  wdata_q  <= wdata_d;
                  mem_we_q <= we_d;
                  mem_re_q <= ~we_d;
                  state_q  <= ACCESS;
               end
            end
            ACCESS: begin
               mem_we_q <= 1'b0;
               mem_re_q <= 1'b0;
               if (we_q) begin
                  ack_a_q <= ~grant_q;
                  ack_b_q <= grant_q;
                  state_q <= ACK;
               end else begin
                  state_q <= CAPTURE;
               end
            end
            CAPTURE: begin
               // Memory output is registered: data from the ACCESS edge is valid now.
               if (grant_q) rdata_b_q <= mem_dataOut;
               else         rdata_a_q <= mem_dataOut;
               ack_a_q <= ~grant_q;
               ack_b_q <= grant_q;
               state_q <= ACK;
            end
            ACK: begin
               ack_a_q  <= 1'b0;
               ack_b_q  <= 1'b0;
               last_b_q <= grant_q;
               xfer_q   <= xfer_q + 8'd1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack_a       = ack_a_q;
   assign ack_b       = ack_b_q;
   assign rdata_a     = rdata_a_q;
   assign rdata_b     = rdata_b_q;
   assign mem_data    = wdata_q;
   assign mem_address = addr_q;
   assign mem_rE      = mem_re_q;
   assign mem_wE      = mem_we_q;
   assign busy        = (state_q != IDLE);
   assign grant_b     = grant_q;
   assign xfer_count  = xfer_q;

endmodule

// File: tb/tb_memory_arbiter_2port.sv
// Directed bench for memory_arbiter_2port with a behavioural 32x8 registered-output memory.
module tb_memory_arbiter_2port;

   logic       clock, reset;
   logic       req_a, we_a, req_b, we_b;
   logic [4:0] addr_a, addr_b;
   logic [7:0] wdata_a, wdata_b;
   logic       ack_a, ack_b;
   logic [7:0] rdata_a, rdata_b;
   logic [7:0] mem_data;
   logic [4:0] mem_address;
   logic       mem_rE, mem_wE;
   logic [7:0] mem_dataOut;
   logic       busy, grant_b;
   logic [7:0] xfer_count;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [32];

   memory_arbiter_2port #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
      .clock(clock), .reset(reset),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .ack_a(ack_a), .rdata_a(rdata_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .ack_b(ack_b), .rdata_b(rdata_b),
      .mem_data(mem_data), .mem_address(mem_address),
      .mem_rE(mem_rE), .mem_wE(mem_wE), .mem_dataOut(mem_dataOut),
      .busy(busy), .grant_b(grant_b), .xfer_count(xfer_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      mem_dataOut = 8'h00;
   end

   always @(posedge clock) begin
      if (mem_wE) mem[mem_address] <= mem_data;
      if (mem_rE) mem_dataOut <= mem[mem_address];
   end

   always @(negedge clock) begin
      total++;
      assert (!(mem_rE && mem_wE)) else begin
         bad++;
         $error("FAIL rE_wE_exclusive observed rE=%0b wE=%0b expected not both", mem_rE, mem_wE);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
      req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_ack_a", ack_a, 0);
      chk("rst_ack_b", ack_b, 0);
      chk("rst_rE", mem_rE, 0);
      chk("rst_wE", mem_wE, 0);
      chk("rst_xfer", xfer_count, 0);
      chk("rst_grant", grant_b, 0);
      chk("rst_rdata_a", rdata_a, 0);
      chk("rst_addr", mem_address, 0);
      step(); step();
      reset = 1'b0;

      // A write addr 5 = 0x3C
      req_a = 1; we_a = 1; addr_a = 5; wdata_a = 8'h3C;
      chk("t1_idle_busy", busy, 0);
      step();
      chk("t1_wE", mem_wE, 1);
      chk("t1_rE", mem_rE, 0);
      chk("t1_addr", mem_address, 5);
      chk("t1_data", mem_data, 8'h3C);
      chk("t1_busy", busy, 1);
      chk("t1_grant", grant_b, 0);
      chk("t1_noack", ack_a, 0);
      addr_a = 9; wdata_a = 8'hFF;
      step();
      chk("t1_ack_a", ack_a, 1);
      chk("t1_ack_b", ack_b, 0);
      chk("t1_wE_off", mem_wE, 0);
      req_a = 0;
      step();
      chk("t1_ack_drop", ack_a, 0);
      chk("t1_idle", busy, 0);
      chk("t1_xfer", xfer_count, 1);
      chk("t1_addr_hold", mem_address, 5);

      // B read addr 5
      req_b = 1; we_b = 0; addr_b = 5;
      step();
      chk("t2_rE", mem_rE, 1);
      chk("t2_wE", mem_wE, 0);
      chk("t2_addr", mem_address, 5);
      chk("t2_grant", grant_b, 1);
      step();
      chk("t2_rE_off", mem_rE, 0);
      chk("t2_noack", ack_b, 0);
      step();
      chk("t2_ack_b", ack_b, 1);
      chk("t2_ack_a", ack_a, 0);
      chk("t2_rdata_b", rdata_b, 8'h3C);
      chk("t2_rdata_a", rdata_a, 0);
      req_b = 0;
      step();
      chk("t2_xfer", xfer_count, 2);

      // simultaneous writes, B served last -> A first
      req_a = 1; we_a = 1; addr_a = 1; wdata_a = 8'h11;
      req_b = 1; we_b = 1; addr_b = 2; wdata_b = 8'h22;
      step();
      chk("t3_grant0", grant_b, 0);
      chk("t3_addr0", mem_address, 1);
      chk("t3_data0", mem_data, 8'h11);
      step();
      chk("t3_ack_a", ack_a, 1);
      chk("t3_ack_b0", ack_b, 0);
      req_a = 0;
      step();
      chk("t3_idle", busy, 0);
      step();
      chk("t3_grant1", grant_b, 1);
      chk("t3_addr1", mem_address, 2);
      chk("t3_data1", mem_data, 8'h22);
      step();
      chk("t3_ack_b", ack_b, 1);
      chk("t3_ack_a0", ack_a, 0);
      req_b = 0;
      step();
      chk("t3_xfer", xfer_count, 4);

      // A-only write addr 0 = 0xA5 leaves A as last served
      req_a = 1; we_a = 1; addr_a = 0; wdata_a = 8'hA5;
      step(); step();
      chk("t3b_ack_a", ack_a, 1);
      req_a = 0;
      step();

      // second simultaneous pair -> B first
      req_a = 1; we_a = 1; addr_a = 3; wdata_a = 8'h33;
      req_b = 1; we_b = 1; addr_b = 4; wdata_b = 8'h44;
      step();
      chk("t3c_grant0", grant_b, 1);
      chk("t3c_addr0", mem_address, 4);
      step();
      chk("t3c_ack_b", ack_b, 1);
      req_b = 0;
      step();
      step();
      chk("t3c_grant1", grant_b, 0);
      chk("t3c_addr1", mem_address, 3);
      step();
      chk("t3c_ack_a", ack_a, 1);
      req_a = 0;
      step();
      chk("t3c_xfer", xfer_count, 7);

      // A holds read requests of addr 0; B issues one read of addr 2
      req_a = 1; we_a = 0; addr_a = 0;
      step();
      chk("t4_grant0", grant_b, 0);
      chk("t4_rE0", mem_rE, 1);
      req_b = 1; we_b = 0; addr_b = 2;
      step();
      step();
      chk("t4_ack_a0", ack_a, 1);
      chk("t4_rdata_a0", rdata_a, 8'hA5);
      step();
      step();
      chk("t4_grant1", grant_b, 1);
      chk("t4_addr1", mem_address, 2);
      step();
      step();
      chk("t4_ack_b", ack_b, 1);
      chk("t4_rdata_b", rdata_b, 8'h22);
      chk("t4_rdata_a_keep", rdata_a, 8'hA5);
      req_b = 0;
      step();
      step();
      chk("t4_grant2", grant_b, 0);
      chk("t4_addr2", mem_address, 0);
      step();
      step();
      chk("t4_ack_a1", ack_a, 1);
      chk("t4_rdata_b_keep", rdata_b, 8'h22);
      req_a = 0;
      step();
      chk("t4_xfer", xfer_count, 10);

      // reset during the ACCESS cycle of a B read
      req_b = 1; we_b = 0; addr_b = 4;
      step();
      chk("t5_rE", mem_rE, 1);
      chk("t5_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("t5_busy_rst", busy, 0);
      chk("t5_rE_rst", mem_rE, 0);
      chk("t5_xfer_rst", xfer_count, 0);
      chk("t5_rdata_b_rst", rdata_b, 0);
      req_b = 0;
      step();
      chk("t5_noack0", ack_b, 0);
      step();
      reset = 1'b0;
      step();
      chk("t5_noack1", ack_b, 0);
      chk("t5_idle", busy, 0);
      req_a = 1; we_a = 1; addr_a = 7; wdata_a = 8'h77;
      step();
      chk("t5_wE", mem_wE, 1);
      step();
      chk("t5_ack_w", ack_a, 1);
      req_a = 0;
      step();
      chk("t5_xfer1", xfer_count, 1);
      req_a = 1; we_a = 0; addr_a = 7;
      step();
      chk("t5_rE_a", mem_rE, 1);
      step();
      step();
      chk("t5_ack_r", ack_a, 1);
      chk("t5_rdata_a", rdata_a, 8'h77);
      req_a = 0;
      step();
      chk("t5_xfer2", xfer_count, 2);

      // 256 back-to-back A writes with req held high
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t6_xfer0", xfer_count, 0);
      req_a = 1; we_a = 1;
      for (int i = 0; i < 256; i++) begin
         addr_a = i[4:0]; wdata_a = i[7:0];
         step();
         chk("t6_wE", mem_wE, 1);
         step();
         chk("t6_ack", ack_a, 1);
         step();
         chk("t6_xfer", xfer_count, (i + 1) % 256);
      end
      addr_a = 5'd31; wdata_a = 8'hEE;
      step();
      step();
      chk("t6_ack257", ack_a, 1);
      req_a = 0;
      step();
      chk("t6_xfer257", xfer_count, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/memory_arbiter_2port.md
Name: memory_arbiter_2port

Overview:
Round-robin arbiter and sequencer that shares one 32-word x 8-bit synchronous memory between two requesters, A and B. It accepts a read or write request from each side and serialises them onto the memory's data/address/rE/wE port. It captures dataOut for reads and returns a one-cycle acknowledge to the requester that was served. It sits directly in front of the memory instance, and both blocks share the same clock and reset nets.

Parameters:
DATA_WIDTH, 8, width of the data words on all data ports.
ADDR_WIDTH, 5, width of the word address; the memory depth is 2**ADDR_WIDTH.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous reset, active-high.
req_a  input  1  requester A access request; held high until ack_a.
we_a  input  1  A access type: 1 = write, 0 = read; sampled at grant.
addr_a  input  ADDR_WIDTH  A word address; sampled at grant.
wdata_a  input  DATA_WIDTH  A write data; sampled at grant.
ack_a  output  1  one-cycle pulse when A's access completes.
rdata_a  output  DATA_WIDTH  A read result; valid from ack_a until A's next read completes.
req_b, we_b, addr_b, wdata_b, ack_b, rdata_b: same as the A ports, for requester B.
mem_data  output  DATA_WIDTH  to memory data.
mem_address  output  ADDR_WIDTH  to memory address.
mem_rE  output  1  to memory read enable.
mem_wE  output  1  to memory write enable.
mem_dataOut  input  DATA_WIDTH  from memory dataOut.
busy  output  1  high in every state except IDLE.
grant_b  output  1  0 = A owns the current transaction, 1 = B owns it; held after completion.
xfer_count  output  8  number of completed transactions; wraps 255 -> 0.

Behaviour:
- Reset values (asynchronous):
  - State = IDLE.
  - All outputs = 0.
  - last_served = B, so A wins the first simultaneous contest.
  - Latched request registers = 0.
- FSM states: IDLE, ACCESS, CAPTURE, ACK.
- IDLE:
  - If req_a or req_b is high, pick a winner, latch its we/addr/wdata, set grant_b, go to ACCESS.
  - With one request pending, that requester wins.
  - With both pending, the requester that is not last_served wins.
  - With no request, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_address = latched addr.
  - mem_data = latched wdata.
  - mem_wE = we; mem_rE = ~we.
  - Next state: CAPTURE for a read, ACK for a write.
- CAPTURE (read only, 1 cycle):
  - The memory output is registered; mem_dataOut is valid during this cycle.
  - The winner's rdata register loads mem_dataOut at the end of the cycle.
  - mem_rE = 0 and mem_wE = 0.
  - Next state: ACK.
- ACK (1 cycle):
  - The winner's ack is high; the other ack stays 0.
  - last_served = winner; xfer_count increments.
  - Next state: IDLE.
- mem_rE and mem_wE are 0 outside ACCESS and are never high together.
- mem_address and mem_data hold their last values outside ACCESS.
- Latency, counted from the first IDLE cycle in which req is high:
  - Read: ack in cycle 3, rdata valid in the same cycle.
  - Write: ack in cycle 2.
  - Peak throughput: one write per 3 cycles or one read per 4 cycles.
- Requester rule: drop req in the cycle after ack.
  - If req is still high in the IDLE cycle after ack, it counts as a new request of the same type.
  - Round-robin still applies, so a waiting opposite requester is served first.
- Changes to we/addr/wdata after grant are ignored until the next grant.
- rdata of the non-granted requester is never modified; a write never modifies either rdata.
- Reset asserted mid-transaction:
  - Return to IDLE immediately; the in-flight access is dropped and no ack is issued.
  - mem_rE and mem_wE fall to 0 asynchronously.
  - xfer_count clears.
- xfer_count wraps 255 -> 0 without a flag.
- Maximum wait for a requester holding req: one opposing transaction (4 cycles) plus its own transaction.

Test Plan:
- Reset, then A write addr 5 data 0x3C -> mem_wE=1, mem_address=5, mem_data=0x3C for exactly one cycle; ack_a 2 cycles after req; xfer_count=1.
- Then B read addr 5 -> mem_rE pulse one cycle; ack_b 3 cycles after req with rdata_b=0x3C; rdata_a unchanged at 0.
- req_a and req_b rise together (A write addr 1 = 0x11, B write addr 2 = 0x22) -> A served first, then B; next simultaneous pair -> B first (alternation); no cycle with mem_rE and mem_wE both high.
- A holds req high continuously for reads of addr 0 while B holds a single request -> grants alternate A, B, A; B acked within 8 cycles of its req.
- Assert reset during the ACCESS cycle of a B read -> no ack_b; busy=0 and mem_rE=0 immediately; xfer_count=0; a subsequent A request is serviced normally.
- 256 back-to-back A writes -> xfer_count wraps to 0; 257th completion reads xfer_count=1.
